// File: rtl/multiplicador_secuencial_if.sv
// Request/response bundle between a requester and the sequential multiplier.
// Latency: none (wiring only).
// Backpressure: requester may only present start while ready is high.
interface multiplicador_secuencial_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 ready;
    logic                 done;
    logic [2*WIDTH-1:0]   P;

    // Requester side: issues operands, watches completion.
    modport master (
        output start,
        output A,
        output B,
        input  ready,
        input  done,
        input  P
    );

    // Multiplier side: accepts operands, returns the product.
    modport slave (
        input  start,
        input  A,
        input  B,
        output ready,
        output done,
        output P
    );
endinterface

// File: rtl/multiplicador_secuencial.sv
// Shift-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH, one multiplier bit per clock.
// Latency: WIDTH clocks from accepted start to done (early exit with MULT_EARLY_EXIT_EN).
// Backpressure: start is honoured only while ready=1; starts during a job are dropped.
//
// Optional build macro: MULT_EARLY_EXIT_EN -- leave MULT as soon as the remaining
// multiplier bits are all zero; the product is identical, only latency shrinks.
module multiplicador_secuencial #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    multiplicador_secuencial_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [PW-1:0]    m;        // multiplicand, shifted left each step
    logic [WIDTH-1:0] q;        // multiplier, shifted right each step
    logic [PW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    p_reg;

    logic [PW-1:0]    pp;
    logic [PW-1:0]    acc_sum;
    logic             last_step;

    // 1-bit multiplier stage, accumulate, and end-of-job detection.
    always_comb begin
        pp      = q[0] ? m : '0;
        acc_sum = acc + pp;
`ifdef MULT_EARLY_EXIT_EN
        // Once the shifted multiplier is empty no further partial product can be nonzero.
        last_step = (cnt == CNT_LAST) || ((q >> 1) == '0);
`else
        last_step = (cnt == CNT_LAST);
`endif
    end

    assign bus.ready = (state == IDLE);
    assign bus.done  = (state == DONE);
    assign bus.P     = p_reg;

    // Control FSM and datapath registers; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            m     <= '0;
            q     <= '0;
            acc   <= '0;
            cnt   <= '0;
            p_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m     <= {{WIDTH{1'b0}}, bus.A};
                        q     <= bus.B;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= MULT;
                    end
                end
                MULT: begin
                    acc <= acc_sum;
                    m   <= m << 1;
                    q   <= q >> 1;
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        // P only ever sees the finished sum, never a partial ACC.
                        p_reg <= acc_sum;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Self-checking bench for multiplicador_secuencial: directed cases plus random jobs.
// Expected products and latencies come from plain arithmetic on the operands.
// Honours MULT_EARLY_EXIT_EN when compiled with the same define as the design.
module tb_multiplicador_secuencial;
    localparam int W  = 4;
    localparam int PW = 2 * W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multiplicador_secuencial_if #(.WIDTH(W)) bus ();

    multiplicador_secuencial #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference: latency in clocks from accepted start to done.
    function automatic int model_latency(input logic [W-1:0] b);
        int l;
`ifdef MULT_EARLY_EXIT_EN
        l = 0;
        while (l < W && (b >> l) != 0) l++;
        if (l == 0) l = 1;
`else
        l = W;
`endif
        return l;
    endfunction

    // Reference: full-width unsigned product.
    function automatic logic [PW-1:0] model_product(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [PW-1:0] r;
        r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one start pulse (sampled at the next edge), then scramble operands.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        step();
        bus.start = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
    endtask

    // Watch a job for a fixed number of cycles after the accepting edge.
    task automatic observe(input int window, output int lat, output int ndone,
                           output logic [PW-1:0] p_done, output bit p_glitch,
                           output bit busy_bad, output bit ready_after);
        logic [PW-1:0] p0;
        p0          = bus.P;
        lat         = -1;
        ndone       = 0;
        p_done      = '0;
        p_glitch    = 1'b0;
        busy_bad    = 1'b0;
        ready_after = 1'b0;
        for (int c = 1; c <= window; c++) begin
            step();
            if (bus.done === 1'b1) begin
                ndone++;
                if (lat < 0) begin
                    lat    = c;
                    p_done = bus.P;
                end
            end
            if (lat < 0 && bus.P !== p0) p_glitch = 1'b1;
            if ((lat < 0 || c == lat) && bus.ready !== 1'b0) busy_bad = 1'b1;
            if (lat > 0 && c == lat + 1) ready_after = (bus.ready === 1'b1);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.A     = 4'd13;
        bus.B     = 4'd11;
        step();
        step();
        vectors++;
        if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b want=1", bus.ready); end
        vectors++;
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b want=0", bus.done); end
        vectors++;
        if (bus.P !== '0) begin miscompares++; $display("FAIL reset_P got=%h want=00", bus.P); end
        rst       = 1'b0;
        bus.start = 1'b0;
        step();
        vectors++;
        if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL reset_no_job ready got=%b want=1", bus.ready); end
    endtask

    task automatic test_basic();
        int lat, nd;
        logic [PW-1:0] pd;
        bit gl, bb, ra;
        issue(4'd13, 4'd11);
        observe(W + 4, lat, nd, pd, gl, bb, ra);
        vectors++;
        if (pd !== 8'h8F) begin miscompares++; $display("FAIL basic_P got=%h want=8f", pd); end
        vectors++;
        if (lat != model_latency(4'd11)) begin miscompares++; $display("FAIL basic_latency got=%0d want=%0d", lat, model_latency(4'd11)); end
        vectors++;
        if (nd != 1) begin miscompares++; $display("FAIL basic_done_count got=%0d want=1", nd); end
        vectors++;
        if (gl || bb || !ra) begin miscompares++; $display("FAIL basic_handshake glitch=%0b busy_err=%0b ready_after=%0b want 0/0/1", gl, bb, ra); end
        step(); step(); step();
        vectors++;
        if (bus.P !== 8'h8F) begin miscompares++; $display("FAIL basic_P_hold got=%h want=8f", bus.P); end
    endtask

    task automatic test_extremes();
        logic [W-1:0]  a_t [3] = '{4'd15, 4'd0, 4'd9};
        logic [W-1:0]  b_t [3] = '{4'd15, 4'd9, 4'd0};
        logic [PW-1:0] p_t [3] = '{8'hE1, 8'h00, 8'h00};
        int lat, nd;
        logic [PW-1:0] pd;
        bit gl, bb, ra;
        for (int i = 0; i < 3; i++) begin
            issue(a_t[i], b_t[i]);
            observe(W + 1, lat, nd, pd, gl, bb, ra);
            vectors++;
            if (pd !== p_t[i] || nd != 1) begin miscompares++; $display("FAIL extremes_P[%0d] got=%h dones=%0d want=%h dones=1", i, pd, nd, p_t[i]); end
            vectors++;
            if (lat != model_latency(b_t[i]) || !ra) begin miscompares++; $display("FAIL extremes_latency[%0d] got=%0d ready_after=%0b want=%0d 1", i, lat, ra, model_latency(b_t[i])); end
        end
    endtask

    task automatic test_busy_ignore();
        int lat = -1;
        int nd = 0;
        logic [PW-1:0] pd = '0;
        issue(4'd6, 4'd7);
        for (int c = 1; c <= W + 6; c++) begin
            if (c == 2) begin bus.start = 1'b1; bus.A = 4'd2; bus.B = 4'd2; end
            if (c == 3) bus.start = 1'b0;
            step();
            if (bus.done === 1'b1) begin
                nd++;
                if (lat < 0) begin lat = c; pd = bus.P; end
            end
        end
        bus.start = 1'b0;
        vectors++;
        if (nd != 1) begin miscompares++; $display("FAIL busy_done_count got=%0d want=1", nd); end
        vectors++;
        if (pd !== 8'h2A) begin miscompares++; $display("FAIL busy_P got=%h want=2a", pd); end
        vectors++;
        if (lat != model_latency(4'd7)) begin miscompares++; $display("FAIL busy_latency got=%0d want=%0d", lat, model_latency(4'd7)); end
    endtask

    task automatic test_reset_mid();
        int lat, nd;
        logic [PW-1:0] pd;
        bit gl, bb, ra;
        int nd_after = 0;
        issue(4'd5, 4'd5);
        step();
        rst = 1'b1;
        step();
        vectors++;
        if (bus.P !== '0 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_state P=%h ready=%b done=%b want 00/1/0", bus.P, bus.ready, bus.done);
        end
        rst = 1'b0;
        for (int c = 0; c < 2 * W; c++) begin
            step();
            if (bus.done === 1'b1) nd_after++;
        end
        vectors++;
        if (nd_after != 0) begin miscompares++; $display("FAIL reset_mid_no_done got=%0d want=0", nd_after); end
        issue(4'd3, 4'd4);
        observe(W + 1, lat, nd, pd, gl, bb, ra);
        vectors++;
        if (pd !== 8'h0C || nd != 1 || lat != model_latency(4'd4)) begin
            miscompares++;
            $display("FAIL reset_mid_next_job P=%h dones=%0d lat=%0d want 0c/1/%0d", pd, nd, lat, model_latency(4'd4));
        end
    endtask

    task automatic test_early_exit();
        logic [W-1:0]  b_t [3] = '{4'd2, 4'd0, 4'd8};
        logic [PW-1:0] p_t [3] = '{8'h0E, 8'h00, 8'h38};
`ifdef MULT_EARLY_EXIT_EN
        int l_t [3] = '{2, 1, 4};
`else
        int l_t [3] = '{4, 4, 4};
`endif
        int lat, nd;
        logic [PW-1:0] pd;
        bit gl, bb, ra;
        for (int i = 0; i < 3; i++) begin
            issue(4'd7, b_t[i]);
            observe(W + 1, lat, nd, pd, gl, bb, ra);
            vectors++;
            if (pd !== p_t[i]) begin miscompares++; $display("FAIL early_P[%0d] got=%h want=%h", i, pd, p_t[i]); end
            vectors++;
            if (lat != l_t[i] || nd != 1) begin miscompares++; $display("FAIL early_latency[%0d] got=%0d dones=%0d want=%0d 1", i, lat, nd, l_t[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int l;
        int nd = 0;
        int d1 = -1;
        int d2 = -1;
        l = model_latency(4'd5);
        bus.start = 1'b1;
        bus.A     = 4'd3;
        bus.B     = 4'd5;
        for (int c = 1; c <= 2 * l + 4; c++) begin
            step();
            if (bus.done === 1'b1) begin
                nd++;
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
        end
        bus.start = 1'b0;
        vectors++;
        if (nd != 2 || d1 != l + 1 || d2 != 2 * l + 3) begin
            miscompares++;
            $display("FAIL back_to_back dones=%0d at %0d,%0d want 2 at %0d,%0d", nd, d1, d2, l + 1, 2 * l + 3);
        end
        vectors++;
        if (bus.P !== 8'h0F) begin miscompares++; $display("FAIL back_to_back_P got=%h want=0f", bus.P); end
        for (int c = 0; c < W + 3; c++) step();
    endtask

    task automatic test_random();
        int lat, nd;
        logic [PW-1:0] pd;
        bit gl, bb, ra;
        logic [W-1:0] a, b;
        for (int i = 0; i < 25; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            issue(a, b);
            observe(W + 1, lat, nd, pd, gl, bb, ra);
            vectors++;
            if (pd !== model_product(a, b)) begin miscompares++; $display("FAIL random_P a=%0d b=%0d got=%h want=%h", a, b, pd, model_product(a, b)); end
            vectors++;
            if (lat != model_latency(b) || nd != 1) begin miscompares++; $display("FAIL random_latency b=%0d got=%0d dones=%0d want=%0d 1", b, lat, nd, model_latency(b)); end
            vectors++;
            if (gl || bb || !ra) begin miscompares++; $display("FAIL random_handshake glitch=%0b busy_err=%0b ready_after=%0b want 0/0/1", gl, bb, ra); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        test_reset();
        test_basic();
        test_extremes();
        test_busy_ignore();
        test_reset_mid();
        test_early_exit();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
